// File: rtl/css_mcu0_el2_dccm_init_arb_pkg.sv
// rtl/css_mcu0_el2_dccm_init_arb_pkg.sv - shared types and DCCM geometry defaults
package css_mcu0_el2_dccm_init_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dccm_init_state_e;

    localparam logic [6:0] INIT_ECC_DEFAULT = 7'h00;

    typedef struct packed {
        int num_banks;
        int bank_bits;
        int dccm_bits;
        int data_width;
        int ecc_width;
    } dccm_cfg_t;

    localparam dccm_cfg_t DCCM_CFG_DEFAULT = '{
        num_banks:  4,
        bank_bits:  2,
        dccm_bits:  16,
        data_width: 32,
        ecc_width:  7
    };

    // Row index bits per bank: byte address minus bank select minus byte-in-word.
    function automatic int row_bits(input dccm_cfg_t cfg);
        return cfg.dccm_bits - cfg.bank_bits - 2;
    endfunction

endpackage

// File: rtl/css_mcu0_el2_dccm_init_arb_if.sv
// rtl/css_mcu0_el2_dccm_init_arb_if.sv - secondary loader port (firmware load / debug)
interface css_mcu0_el2_dccm_init_arb_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int ECC_W  = 7
);
    logic              ldr_valid;
    logic              ldr_ready;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [ECC_W-1:0]  ldr_wecc;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;
    logic [ECC_W-1:0]  ldr_recc;

    modport master (
        output ldr_valid, ldr_we, ldr_addr, ldr_wdata, ldr_wecc,
        input  ldr_ready, ldr_rvalid, ldr_rdata, ldr_recc
    );

    modport slave (
        input  ldr_valid, ldr_we, ldr_addr, ldr_wdata, ldr_wecc,
        output ldr_ready, ldr_rvalid, ldr_rdata, ldr_recc
    );
endinterface

// File: rtl/css_mcu0_el2_dccm_init_arb.sv
// rtl/css_mcu0_el2_dccm_init_arb.sv - DCCM zero-init sweep, core pass-through, idle-slot loader access
module css_mcu0_el2_dccm_init_arb
    import css_mcu0_el2_dccm_init_arb_pkg::*;
#(
    parameter int DCCM_NUM_BANKS  = DCCM_CFG_DEFAULT.num_banks,
    parameter int DCCM_BANK_BITS  = DCCM_CFG_DEFAULT.bank_bits,
    parameter int DCCM_BITS       = DCCM_CFG_DEFAULT.dccm_bits,
    parameter int DCCM_DATA_WIDTH = DCCM_CFG_DEFAULT.data_width,
    parameter int DCCM_ECC_WIDTH  = DCCM_CFG_DEFAULT.ecc_width,
    parameter logic [DCCM_ECC_WIDTH-1:0] INIT_ECC = INIT_ECC_DEFAULT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      init_req,
    output logic                                      init_done,
    output logic                                      init_viol,
    input  logic [DCCM_NUM_BANKS-1:0]                 core_clken,
    input  logic [DCCM_NUM_BANKS-1:0]                 core_wren,
    input  logic [DCCM_NUM_BANKS*(DCCM_BITS-DCCM_BANK_BITS-2)-1:0] core_addr,
    input  logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0] core_wr_data,
    input  logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]  core_wr_ecc,
    output logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0] core_dout,
    output logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]  core_ecc,
    output logic [DCCM_NUM_BANKS-1:0]                 sram_clken,
    output logic [DCCM_NUM_BANKS-1:0]                 sram_wren,
    output logic [DCCM_NUM_BANKS*(DCCM_BITS-DCCM_BANK_BITS-2)-1:0] sram_addr,
    output logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0] sram_wr_data,
    output logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]  sram_wr_ecc,
    input  logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0] sram_dout,
    input  logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]  sram_ecc,
    css_mcu0_el2_dccm_init_arb_if.slave               ldr
);

    localparam int NB    = DCCM_NUM_BANKS;
    localparam int AW    = DCCM_BITS - DCCM_BANK_BITS - 2;
    localparam int DEPTH = 2 ** AW;
    localparam int DW    = DCCM_DATA_WIDTH;
    localparam int EW    = DCCM_ECC_WIDTH;

    dccm_init_state_e          state;
    dccm_init_state_e          state_next;
    logic [AW-1:0]             row_cnt;
    logic [DCCM_BANK_BITS-1:0] rd_bank;
    logic [DCCM_BANK_BITS-1:0] ldr_bank;
    logic [AW-1:0]             ldr_row;
    logic                      core_active;
    logic                      sweep_last;

    assign core_active = |core_clken;
    assign sweep_last  = (row_cnt == AW'(DEPTH - 1));
    assign ldr_bank    = ldr.ldr_addr[DCCM_BANK_BITS-1:0];
    assign ldr_row     = ldr.ldr_addr[DCCM_BITS-3:DCCM_BANK_BITS];

    // Loader only gets slots the core leaves empty; the core is never stalled.
    assign ldr.ldr_ready = ldr.ldr_valid & ~core_active & (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (init_req) begin
            state_next = INIT;
        end else if (state == INIT && sweep_last) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init_req) begin
            row_cnt <= '0;
        end else if (state == INIT) begin
            row_cnt <= row_cnt + AW'(1);
        end else begin
            row_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done      <= 1'b0;
            init_viol      <= 1'b0;
            ldr.ldr_rvalid <= 1'b0;
            rd_bank        <= '0;
        end else begin
            init_done      <= (state_next == RUN);
            init_viol      <= init_viol | ((state == INIT) & core_active);
            ldr.ldr_rvalid <= ldr.ldr_ready & ~ldr.ldr_we;
            if (ldr.ldr_ready) begin
                rd_bank <= ldr_bank;
            end
        end
    end

    always_comb begin
        sram_clken   = '0;
        sram_wren    = '0;
        sram_addr    = '0;
        sram_wr_data = '0;
        sram_wr_ecc  = '0;
        case (state)
            INIT: begin
                sram_clken  = '1;
                sram_wren   = '1;
                sram_addr   = {NB{row_cnt}};
                sram_wr_ecc = {NB{INIT_ECC}};
            end
            RUN: begin
                if (core_active) begin
                    sram_clken   = core_clken;
                    sram_wren    = core_wren;
                    sram_addr    = core_addr;
                    sram_wr_data = core_wr_data;
                    sram_wr_ecc  = core_wr_ecc;
                end else if (ldr.ldr_ready) begin
                    sram_clken[ldr_bank]            = 1'b1;
                    sram_wren[ldr_bank]             = ldr.ldr_we;
                    sram_addr[ldr_bank*AW +: AW]    = ldr_row;
                    sram_wr_data[ldr_bank*DW +: DW] = ldr.ldr_wdata;
                    sram_wr_ecc[ldr_bank*EW +: EW]  = ldr.ldr_wecc;
                end
            end
            default: begin
                sram_clken = '0;
            end
        endcase
    end

    assign core_dout     = sram_dout;
    assign core_ecc      = sram_ecc;
    assign ldr.ldr_rdata = sram_dout[rd_bank*DW +: DW];
    assign ldr.ldr_recc  = sram_ecc[rd_bank*EW +: EW];

endmodule

// File: tb/tb_css_mcu0_el2_dccm_init_arb.sv
// tb/tb_css_mcu0_el2_dccm_init_arb.sv - directed bench for the DCCM init arbiter
module tb_css_mcu0_el2_dccm_init_arb;

    localparam int NB    = 4;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_req;
    logic          init_done;
    logic          init_viol;
    logic [3:0]    core_clken;
    logic [3:0]    core_wren;
    logic [47:0]   core_addr;
    logic [127:0]  core_wr_data;
    logic [27:0]   core_wr_ecc;
    logic [127:0]  core_dout;
    logic [27:0]   core_ecc;
    logic [3:0]    sram_clken;
    logic [3:0]    sram_wren;
    logic [47:0]   sram_addr;
    logic [127:0]  sram_wr_data;
    logic [27:0]   sram_wr_ecc;
    logic [127:0]  sram_dout = '0;
    logic [27:0]   sram_ecc  = '0;

    int errors = 0;
    int checks = 0;

    css_mcu0_el2_dccm_init_arb_if #(.ADDR_W(14), .DATA_W(32), .ECC_W(7)) ldr_if ();

    css_mcu0_el2_dccm_init_arb dut (
        .clk          (clk),
        .rst          (rst),
        .init_req     (init_req),
        .init_done    (init_done),
        .init_viol    (init_viol),
        .core_clken   (core_clken),
        .core_wren    (core_wren),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_wr_ecc  (core_wr_ecc),
        .core_dout    (core_dout),
        .core_ecc     (core_ecc),
        .sram_clken   (sram_clken),
        .sram_wren    (sram_wren),
        .sram_addr    (sram_addr),
        .sram_wr_data (sram_wr_data),
        .sram_wr_ecc  (sram_wr_ecc),
        .sram_dout    (sram_dout),
        .sram_ecc     (sram_ecc),
        .ldr          (ldr_if)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM banks: one-cycle read latency, write-through to storage.
    logic [38:0] mem [NB][DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (sram_clken[b]) begin
                if (sram_wren[b])
                    mem[b][sram_addr[b*AW +: AW]] <= {sram_wr_ecc[b*7 +: 7], sram_wr_data[b*32 +: 32]};
                else
                    {sram_ecc[b*7 +: 7], sram_dout[b*32 +: 32]} <= mem[b][sram_addr[b*AW +: AW]];
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc sweep cycles starting at row 0; optionally pokes the core at one cycle.
    task automatic sweep(input int ncyc, input int viol_at);
        int bad;
        logic [11:0] r;
        bad = 0;
        ldr_if.ldr_valid = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            r = 12'(i);
            core_clken   = (i == viol_at) ? 4'b0010 : 4'b0000;
            core_wren    = (i == viol_at) ? 4'b0010 : 4'b0000;
            core_wr_data = (i == viol_at) ? {4{32'h5A5A_5A5A}} : '0;
            #3;
            if (sram_clken !== 4'hF || sram_wren !== 4'hF || sram_addr !== {4{r}} ||
                sram_wr_data !== 128'h0 || sram_wr_ecc !== 28'h0 ||
                ldr_if.ldr_ready !== 1'b0 || init_done !== 1'b0)
                bad++;
            tick();
        end
        core_clken       = '0;
        core_wren        = '0;
        core_wr_data     = '0;
        ldr_if.ldr_valid = 1'b0;
        chk("sweep_bad_cycles", 128'(bad), 128'h0);
    endtask

    initial begin
        rst = 1'b1; init_req = 1'b0;
        core_clken = '0; core_wren = '0; core_addr = '0; core_wr_data = '0; core_wr_ecc = '0;
        ldr_if.ldr_valid = 1'b0; ldr_if.ldr_we = 1'b0; ldr_if.ldr_addr = '0;
        ldr_if.ldr_wdata = '0; ldr_if.ldr_wecc = '0;

        tick();
        #3;
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_init_viol", init_viol, 1'b0);
        chk("rst_rvalid", ldr_if.ldr_rvalid, 1'b0);
        tick();
        rst = 1'b0;

        // First sweep with a core access attempted at row 10.
        sweep(DEPTH, 10);

        // Loader write 0x0005 -> bank1 row1.
        ldr_if.ldr_valid = 1'b1; ldr_if.ldr_we = 1'b1; ldr_if.ldr_addr = 14'h0005;
        ldr_if.ldr_wdata = 32'hDEAD_BEEF; ldr_if.ldr_wecc = 7'h2A;
        #3;
        chk("init_done_after_sweep", init_done, 1'b1);
        chk("init_viol_sticky", init_viol, 1'b1);
        chk("wr_ready", ldr_if.ldr_ready, 1'b1);
        chk("wr_clken", sram_clken, 4'b0010);
        chk("wr_wren", sram_wren, 4'b0010);
        chk("wr_addr", sram_addr, 48'h0000_0000_1000);
        chk("wr_data", sram_wr_data, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000);
        chk("wr_ecc", sram_wr_ecc, 28'h000_1500);
        tick();

        ldr_if.ldr_we = 1'b0;
        #3;
        chk("rd_ready", ldr_if.ldr_ready, 1'b1);
        chk("wr_no_rvalid", ldr_if.ldr_rvalid, 1'b0);
        chk("rd_clken", sram_clken, 4'b0010);
        chk("rd_wren", sram_wren, 4'b0000);
        tick();

        ldr_if.ldr_valid = 1'b0;
        #3;
        chk("rd_rvalid", ldr_if.ldr_rvalid, 1'b1);
        chk("rd_rdata", ldr_if.ldr_rdata, 32'hDEAD_BEEF);
        chk("rd_recc", ldr_if.ldr_recc, 7'h2A);
        chk("core_dout_route", core_dout, sram_dout);
        chk("idle_clken", sram_clken, 4'b0000);
        chk("idle_addr", sram_addr, 48'h0);
        chk("idle_data", sram_wr_data, 128'h0);
        tick();

        #3;
        chk("rvalid_single", ldr_if.ldr_rvalid, 1'b0);
        tick();

        // Core holds bank0 for three cycles while the loader waits to write bank2 row2.
        ldr_if.ldr_valid = 1'b1; ldr_if.ldr_we = 1'b1; ldr_if.ldr_addr = 14'h000A;
        ldr_if.ldr_wdata = 32'h1111_1111; ldr_if.ldr_wecc = 7'h33;
        core_clken = 4'b0001; core_wren = 4'b0001;
        core_addr = 48'hFFF_FFF_FFF_007;
        core_wr_data = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'hCAFE_F00D};
        core_wr_ecc = {7'h01, 7'h02, 7'h03, 7'h15};
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("core_ready_blocked", ldr_if.ldr_ready, 1'b0);
            chk("core_clken_pass", sram_clken, 4'b0001);
            chk("core_wren_pass", sram_wren, 4'b0001);
            chk("core_addr_pass", sram_addr, 48'hFFF_FFF_FFF_007);
            chk("core_data_pass", sram_wr_data, {32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'hCAFE_F00D});
            chk("core_ecc_pass", sram_wr_ecc, {7'h01, 7'h02, 7'h03, 7'h15});
            tick();
        end
        core_clken = '0; core_wren = '0; core_addr = '0; core_wr_data = '0; core_wr_ecc = '0;
        #3;
        chk("granted_4th_ready", ldr_if.ldr_ready, 1'b1);
        chk("granted_4th_clken", sram_clken, 4'b0100);
        chk("granted_4th_addr", sram_addr, 48'h0000_0200_0000);
        tick();

        // Back-to-back reads: bank0 row7, bank2 row2, bank2 row3.
        ldr_if.ldr_we = 1'b0; ldr_if.ldr_addr = 14'h001C;
        #3;
        chk("b2b_rd0_clken", sram_clken, 4'b0001);
        tick();
        ldr_if.ldr_addr = 14'h000A;
        #3;
        chk("b2b_rd0_rvalid", ldr_if.ldr_rvalid, 1'b1);
        chk("b2b_rd0_rdata", ldr_if.ldr_rdata, 32'hCAFE_F00D);
        chk("b2b_rd0_recc", ldr_if.ldr_recc, 7'h15);
        chk("b2b_rd1_clken", sram_clken, 4'b0100);
        tick();
        ldr_if.ldr_addr = 14'h000E;
        #3;
        chk("b2b_rd1_rdata", ldr_if.ldr_rdata, 32'h1111_1111);
        chk("b2b_rd1_recc", ldr_if.ldr_recc, 7'h33);
        tick();
        ldr_if.ldr_valid = 1'b0;
        #3;
        chk("b2b_rd2_rvalid", ldr_if.ldr_rvalid, 1'b1);
        chk("b2b_rd2_rdata", ldr_if.ldr_rdata, 32'h0);
        tick();

        // Read accepted in the same cycle as init_req.
        ldr_if.ldr_valid = 1'b1; ldr_if.ldr_addr = 14'h0005; init_req = 1'b1;
        #3;
        chk("req_rd_ready", ldr_if.ldr_ready, 1'b1);
        tick();
        ldr_if.ldr_valid = 1'b0; init_req = 1'b0;
        #3;
        chk("req_rd_rvalid", ldr_if.ldr_rvalid, 1'b1);
        chk("req_rd_rdata", ldr_if.ldr_rdata, 32'hDEAD_BEEF);
        chk("req_init_done_drop", init_done, 1'b0);
        sweep(DEPTH, -1);
        #3;
        chk("resweep_init_done", init_done, 1'b1);
        chk("resweep_viol_kept", init_viol, 1'b1);
        tick();

        // init_req held high pins the counter at row 0.
        init_req = 1'b1;
        tick();
        #3;
        chk("hold_req_addr0", sram_addr, 48'h0);
        chk("hold_req_done", init_done, 1'b0);
        tick();
        #3;
        chk("hold_req_addr0_b", sram_addr, 48'h0);
        tick();
        init_req = 1'b0;
        sweep(100, -1);

        // Reset at row 100 restarts the sweep.
        rst = 1'b1;
        #3;
        chk("row100_addr", sram_addr, {4{12'd100}});
        tick();
        rst = 1'b0;
        #3;
        chk("rst_clears_viol", init_viol, 1'b0);
        chk("rst_clears_done", init_done, 1'b0);
        sweep(DEPTH, -1);
        #3;
        chk("final_init_done", init_done, 1'b1);
        chk("final_viol_clear", init_viol, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/css_mcu0_el2_dccm_init_arb.md
Name: css_mcu0_el2_dccm_init_arb

Overview:
Sits between the VeeR DCCM master port and the DCCM SRAM banks. After reset, or on request, it sweeps every DCCM row in all banks, writing zero data with a fixed ECC. It then passes core traffic straight through. It also grants a secondary loader port (firmware load and debug) single-word access to DCCM on cycles the core leaves idle.

Parameters:
DCCM_NUM_BANKS, 4, number of DCCM banks (power of 2)
DCCM_BANK_BITS, 2, log2(DCCM_NUM_BANKS)
DCCM_BITS, 16, byte-address width of DCCM
DCCM_DATA_WIDTH, 32, data bits per bank word
DCCM_ECC_WIDTH, 7, ECC bits per bank word
INIT_ECC, 7'h00, ECC value written with zero data during init
AW (local), DCCM_BITS-DCCM_BANK_BITS-2, per-bank row index width; DEPTH=2**AW

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
init_req  in  1  pulse, restart DCCM init sweep
init_done  out  1  high once sweep complete; integration holds core in reset until high
init_viol  out  1  sticky: core asserted any clken while init_done=0; cleared by rst only
core_clken  in  NB  core per-bank clock enable
core_wren  in  NB  core per-bank write enable
core_addr  in  NB*AW  core per-bank row index
core_wr_data  in  NB*32  core write data
core_wr_ecc  in  NB*7  core write ECC
core_dout  out  NB*32  read data to core
core_ecc  out  NB*7  read ECC to core
sram_clken  out  NB  per-bank enable to SRAM
sram_wren  out  NB  per-bank write enable to SRAM
sram_addr  out  NB*AW  per-bank row to SRAM
sram_wr_data  out  NB*32  write data to SRAM
sram_wr_ecc  out  NB*7  write ECC to SRAM
sram_dout  in  NB*32  SRAM read data, valid the cycle after a read enable
sram_ecc  in  NB*7  SRAM read ECC
ldr_valid  in  1  loader request valid
ldr_ready  out  1  loader request accepted this cycle
ldr_we  in  1  1=write, 0=read
ldr_addr  in  DCCM_BITS-2  word address
ldr_wdata  in  32  loader write data
ldr_wecc  in  7  loader write ECC (loader computes ECC)
ldr_rvalid  out  1  loader read data valid
ldr_rdata  out  32  loader read data
ldr_recc  out  7  loader read ECC

Behaviour:
- FSM states are INIT and RUN. On rst: state=INIT, row counter=0, init_done=0, init_viol=0, ldr_rvalid=0, registered read-bank index=0.
- INIT:
  - Each cycle drives sram_clken=all-1, sram_wren=all-1, sram_addr=counter in every bank, sram_wr_data=0, sram_wr_ecc=INIT_ECC.
  - Counter increments by 1. At counter=DEPTH-1 the write occurs, then state moves to RUN next cycle. Sweep is exactly DEPTH cycles.
  - init_done is registered and rises the first RUN cycle.
  - ldr_ready=0 throughout INIT.
  - Any core_clken bit set sets init_viol. The core request is dropped.
- RUN: init_req=1 moves state to INIT with counter=0 next cycle and init_done=0 next cycle. The same rule applies in INIT: init_req restarts the counter at 0.
- RUN, core path:
  - When any core_clken bit is set, all sram_* outputs equal the core inputs (combinational pass-through). Zero added latency.
  - The core has absolute priority; VeeR cannot be stalled.
- RUN, loader path:
  - ldr_ready = ldr_valid & (core_clken==0) & state==RUN, combinational.
  - On accept: bank=ldr_addr[DCCM_BANK_BITS-1:0], row=ldr_addr[DCCM_BITS-3:DCCM_BANK_BITS].
  - Only that bank gets clken=1 and wren=ldr_we, with addr/data/ecc from the loader. Other banks get clken=0.
- Loader read:
  - ldr_rvalid is registered and asserts exactly 1 cycle after an accepted read.
  - ldr_rdata/ldr_recc mux sram_dout/sram_ecc by the bank index registered at accept.
  - An accepted write produces no rvalid.
- Read-data routing: core_dout/core_ecc = sram_dout/sram_ecc at all times, unregistered. The core ignores cycles it did not request.
- Idle: with no core or loader access, all sram_clken=0. Addr/data outputs are don't-care but held at 0 to limit toggling.
- Boundary cases:
  - A read accepted in the last RUN cycle before init_req still returns ldr_rvalid the next cycle.
  - Back-to-back loader accepts every cycle are legal.
  - Loader accesses to the same bank back-to-back are legal.
  - rst asserted mid-sweep restarts the sweep at row 0.
  - init_req held high keeps the counter at 0 (no progress).

Decomposition:
- Shared package (css_mcu0_el2_pkg) holds the dccm_init_state_e enum (INIT, RUN) and the INIT_ECC default constant.
- Bank index and row slicing are derived from the existing DCCM parameters in the package parameter struct.
- No sub-module: the design is flat, one FSM plus counter plus mux, roughly 200 lines.

Test Plan:
- Reset release, NB=4, AW=12 -> sram_wren=4'hF, rows 0..4095 with data 0 and ECC 0 for 4096 cycles; init_done=1 on cycle 4096; ldr_ready=0 throughout.
- Core clken=4'b0010 at cycle 10 of init -> no SRAM effect from core, init_viol=1 and stays 1 until rst.
- RUN, loader write addr=14'h0005 data 32'hDEADBEEF ecc 7'h2A, then read same -> bank1 row1 written; ldr_rvalid one cycle after read accept with DEADBEEF/2A.
- ldr_valid held high while core_clken=4'b0001 for 3 cycles -> ldr_ready=0 for those 3 cycles, granted the 4th; core writes reach SRAM unchanged.
- init_req in RUN right after an accepted loader read -> rvalid delivered next cycle; init_done drops; full 4096-cycle sweep reruns.
- rst pulsed at init row 100 -> sweep restarts at row 0; init_done rises 4096 cycles after rst release.
